// File: rtl/output_drain_if.sv
// Handshake bundle for output_drain: the result-RAM read port and the
// streamed output port, plus the run-control strobes.
// "master" is the drain engine side, "slave" is the environment side
// (RAM plus downstream consumer plus controller).
interface output_drain_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 19
);
  logic                     start;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, rd_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, rd_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/output_drain.sv
// output_drain: reads DEPTH result words from a 1-cycle-latency RAM in
// address order and streams them out through a small credit-managed buffer.
// All outputs are registered; next-state values are computed in one
// always_comb and latched in one always_ff.
module output_drain #(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  output_drain_if.master io
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_cnt_q, addr_cnt_d;
  logic                     all_issued_q, all_issued_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic                     inflight_q, inflight_d;
  logic                     inflight_last_q, inflight_last_d;
  logic signed [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic signed [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     push_s;
  logic                     pop_s;
  logic                     issue_s;
  logic [CNT_W:0]           credit_s;
  logic                     can_issue_s;

  // Next-state logic: buffer bookkeeping, read credit, run sequencing.
  always_comb begin
    state_d         = state_q;
    addr_cnt_d      = addr_cnt_q;
    all_issued_d    = all_issued_q;
    rd_addr_d       = rd_addr_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    issue_s         = 1'b0;

    // The RAM answers one cycle after rd_en, so the previous strobe is the
    // only read that can be outstanding; its data is captured this cycle.
    push_s          = inflight_q;
    pop_s           = out_valid_q && io.out_ready;
    inflight_d      = rd_en_q;
    inflight_last_d = rd_en_q && (rd_addr_q == LAST_ADDR);

    if (push_s) begin
      fifo_data_d[wr_ptr_q] = io.rd_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d              = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

    // Occupancy next cycle plus the read issued this cycle (still in flight
    // next cycle) must leave room for one more word.
    credit_s    = {1'b0, count_d} + (CNT_W + 1)'(rd_en_q);
    can_issue_s = (credit_s < (CNT_W + 1)'(FIFO_DEPTH));

    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          state_d = S_READ;
          issue_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (all_issued_q) begin
          state_d = S_FLUSH;
        end else begin
          issue_s = can_issue_s;
        end
      end
      S_FLUSH: begin
        if (pop_s && out_last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        addr_cnt_d   = '0;
        all_issued_d = 1'b0;
      end
      default: begin
        state_d      = S_IDLE;
        addr_cnt_d   = '0;
        all_issued_d = 1'b0;
      end
    endcase

    if (issue_s) begin
      rd_addr_d    = addr_cnt_q;
      addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
      all_issued_d = (addr_cnt_q == LAST_ADDR);
    end else begin
      rd_addr_d    = rd_addr_q;
    end
    rd_en_d = issue_s;

    // Output registers look ahead to the post-update buffer head so that a
    // word captured into an empty buffer appears on the very next cycle.
    out_valid_d = (count_d != '0);
    if (out_valid_d) begin
      out_data_d = fifo_data_d[rd_ptr_d];
      out_last_d = fifo_last_d[rd_ptr_d];
    end else begin
      out_data_d = '0;
      out_last_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_cnt_q      <= '0;
      all_issued_q    <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_cnt_q      <= addr_cnt_d;
      all_issued_q    <= all_issued_d;
      rd_en_q         <= rd_en_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign io.rd_en     = rd_en_q;
  assign io.rd_addr   = rd_addr_q;
  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
endmodule

// File: tb/tb_output_drain.sv
// Self-checking bench for output_drain: a cycle-level vector table for the
// run start-up and credit stall, then scoreboarded runs against a RAM image.
module tb_output_drain;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 19;
  localparam int FD     = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  output_drain #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  logic signed [DATA_W-1:0] mem [DEPTH];

  // RAM model: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) bus.rd_data <= mem[bus.rd_addr];
    else                    bus.rd_data <= DATA_W'($urandom);
  end

  typedef struct {
    logic signed [DATA_W-1:0] data;
    logic                     last;
  } word_t;

  typedef struct {
    logic rst, start, rdy;
    logic exp_rd_en;
    int   exp_addr;
    logic exp_valid;
    int   exp_data;
    logic exp_last, exp_busy, exp_done;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    issued   = 0;
  int    last_xfer_cyc = -1;
  int    first_valid_cyc = -1;
  bit    checks_on = 1'b0;
  bit    stall_q   = 1'b0;
  logic signed [DATA_W-1:0] stall_data;
  logic  stall_last;
  word_t recv [$];
  word_t saved [$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: apply inputs, observe protocol, advance, record transfers.
  task automatic cycle(input logic r, input logic s, input logic rdy);
    logic  xfer;
    word_t w;
    reset = r; bus.start = s; bus.out_ready = rdy;
    xfer   = checks_on && !r && (bus.out_valid === 1'b1) && rdy;
    w.data = bus.out_data;
    w.last = bus.out_last;
    if (checks_on && !r) begin
      if (stall_q) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_held", bus.out_data, stall_data);
        check("stall_last_held", bus.out_last, stall_last);
      end
      if (bus.rd_en === 1'b1) begin
        check("rd_addr_order", bus.rd_addr, issued);
        check("rd_en_only_when_busy", bus.busy, 1);
        issued++;
        check("credit_bound", longint'((issued - recv.size()) <= FD), 1);
      end
      if (first_valid_cyc < 0 && bus.out_valid === 1'b1) first_valid_cyc = cyc;
    end
    stall_q    = checks_on && !r && (bus.out_valid === 1'b1) && !rdy;
    stall_data = bus.out_data;
    stall_last = bus.out_last;
    @(posedge clk); #1;
    cyc++;
    if (xfer) begin
      recv.push_back(w);
      last_xfer_cyc = cyc;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},     bus.rd_en, 0);
    check({tag, "_rd_addr"},   bus.rd_addr, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
  endtask

  // One drain run. mode 0: ready always 1; 1: random 50%; 2: ready 0 for 20 cycles.
  task automatic run(input int mode, input int inject_at, input int reset_at);
    int   start_edge;
    int   done_cyc;
    bit   injected;
    logic rdy;
    logic s;
    issued = 0; recv.delete(); first_valid_cyc = -1; done_cyc = -1; injected = 1'b0;
    cycle(1'b0, 1'b1, (mode == 2) ? 1'b0 : 1'b1);
    start_edge = cyc;
    for (int k = 0; k < 2000 && done_cyc < 0; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = ((cyc - start_edge) >= 20);
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && (cyc - start_edge) == 20) begin
        check("stall_reads_issued", issued, FD);
        check("stall_head_word", bus.out_data, mem[0]);
      end
      if (reset_at >= 0 && recv.size() == reset_at) begin
        cycle(1'b1, 1'b0, rdy);
        check_reset_outputs("abort");
        issued = 0; recv.delete();
        return;
      end
      s = (inject_at >= 0) && !injected && (recv.size() == inject_at);
      if (s) injected = 1'b1;
      cycle(1'b0, s, rdy);
      if (bus.done === 1'b1) done_cyc = cyc;
    end
    check("done_seen", longint'(done_cyc >= 0), 1);
    if (done_cyc >= 0) check("done_after_last_xfer", done_cyc, last_xfer_cyc);
    check("busy_during_done", bus.busy, 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("done_single_pulse", bus.done, 0);
    check("busy_low_after_done", bus.busy, 0);
    check("word_count", recv.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < recv.size(); i++) begin
      check($sformatf("word%0d_data", i), recv[i].data, mem[i]);
      check($sformatf("word%0d_last", i), recv[i].last, longint'(i == DEPTH - 1));
    end
    if (mode == 0) begin
      check("first_valid_latency", first_valid_cyc - start_edge, 2);
      check("run_length", done_cyc - start_edge, DEPTH + 2);
    end
  endtask

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i - 32);
    reset = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b0;

    // rst start rdy | rd_en addr valid data last busy done
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0,   0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0,   0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0,   0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0,   0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, -32, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, -32, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, -32, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, -32, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, -31, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, -31, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].start, tbl[i].rdy);
      checks_on = 1'b1;
      check($sformatf("vec%0d_rd_en", i), bus.rd_en, tbl[i].exp_rd_en);
      check($sformatf("vec%0d_rd_addr", i), bus.rd_addr, tbl[i].exp_addr);
      check($sformatf("vec%0d_valid", i), bus.out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("vec%0d_data", i), bus.out_data, tbl[i].exp_data);
      check($sformatf("vec%0d_last", i), bus.out_last, tbl[i].exp_last);
      check($sformatf("vec%0d_busy", i), bus.busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_done", i), bus.done, tbl[i].exp_done);
    end

    // Abort the table's run, make sure the returning read is dropped.
    cycle(1'b1, 1'b0, 1'b0);
    check_reset_outputs("tbl_reset");
    issued = 0; recv.delete();
    cycle(1'b0, 1'b0, 1'b1);
    check("post_reset_no_valid", bus.out_valid, 0);

    run(0, -1, -1);                    // ramp pattern, ready held high
    saved = recv;
    run(2, -1, -1);                    // 20-cycle back-pressure at start
    run(0, 10, -1);                    // start re-pulsed at word 10
    run(0, -1, 30);                    // reset at word 30
    check_reset_outputs("after_abort");
    cycle(1'b0, 1'b0, 1'b1);
    check("abort_data_dropped", bus.out_valid, 0);
    check("abort_no_read", bus.rd_en, 0);
    run(0, -1, -1);                    // clean restart from address 0

    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    mem[5]  = -19'sd262144;
    mem[40] = 19'sd262143;
    mem[63] = -19'sd1;
    run(1, -1, -1);
    run(1, -1, -1);

    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i - 32);
    run(0, -1, -1);                    // back-to-back: second start right after done
    check("b2b_count", recv.size(), saved.size());
    for (int i = 0; i < recv.size() && i < saved.size(); i++) begin
      check($sformatf("b2b_word%0d", i), recv[i].data, saved[i].data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
